// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scanner states, LCD character codes for each key,
// and the (row, column) to code map used by both the scanner and the LCD decode.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_e;

    localparam logic [7:0] KEY_0      = 8'h00;
    localparam logic [7:0] KEY_1      = 8'h01;
    localparam logic [7:0] KEY_2      = 8'h02;
    localparam logic [7:0] KEY_3      = 8'h03;
    localparam logic [7:0] KEY_4      = 8'h04;
    localparam logic [7:0] KEY_5      = 8'h05;
    localparam logic [7:0] KEY_6      = 8'h06;
    localparam logic [7:0] KEY_7      = 8'h07;
    localparam logic [7:0] KEY_8      = 8'h08;
    localparam logic [7:0] KEY_9      = 8'h09;
    localparam logic [7:0] KEY_LPAREN = 8'h0A;
    localparam logic [7:0] KEY_RPAREN = 8'h0B;
    localparam logic [7:0] KEY_EQ     = 8'h0C;
    localparam logic [7:0] KEY_MINUS  = 8'h0D;
    localparam logic [7:0] KEY_DIV    = 8'h0E;
    localparam logic [7:0] KEY_CLR    = 8'h0F;

    function automatic logic [7:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [7:0] code;
        code = KEY_0;
        case ({row_idx, col_idx})
            4'h0: code = KEY_1;
            4'h1: code = KEY_2;
            4'h2: code = KEY_3;
            4'h3: code = KEY_LPAREN;
            4'h4: code = KEY_4;
            4'h5: code = KEY_5;
            4'h6: code = KEY_6;
            4'h7: code = KEY_RPAREN;
            4'h8: code = KEY_7;
            4'h9: code = KEY_8;
            4'hA: code = KEY_9;
            4'hB: code = KEY_DIV;
            4'hC: code = KEY_CLR;
            4'hD: code = KEY_0;
            4'hE: code = KEY_EQ;
            4'hF: code = KEY_MINUS;
            default: code = KEY_0;
        endcase
        return code;
    endfunction

    function automatic logic one_low(input logic [3:0] rs);
        return $countones(~rs) == 1;
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] rs);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the key-code output bundle toward the LCD driver.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row, output col, output key_code, output key_valid, output key_held);
    modport slave  (output row, input col, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer with async active-low reset to a caller-supplied value.
// Latency two clocks; no backpressure.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= rst_val_i;
            sync_q <= rst_val_i;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-cold column scan, debounced press/release, one KEY_VALID per press.
// Accept latency DEBOUNCE_CYCLES+1 from the sampling cycle; no backpressure, codes hold until next press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    keypad_scanner_if.master        kp
);
    localparam int CNT_SPAN = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW       = $clog2(CNT_SPAN) + 1;
    localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_TC    = CW'(DEBOUNCE_CYCLES - 1);

    logic       rst_core_n;
    logic [3:0] rs;

    // Assertion propagates asynchronously; release reaches the FSM two clocks later.
    sync2 #(.WIDTH(1)) u_rst_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rst_val_i (1'b0),
        .d_i       (1'b1),
        .q_o       (rst_core_n)
    );

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rst_val_i (4'hF),
        .d_i       (kp.row),
        .q_o       (rs)
    );

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [1:0]  row_idx_q, row_idx_d;
    logic [7:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic        key_held_q, key_held_d;
    logic [3:0]  row_pat;

    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign row_pat = ~(4'b0001 << row_idx_q);

    always_ff @(posedge clk_i or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q     <= ST_DRIVE;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            key_code_q  <= 8'h00;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        case (state_q)
            ST_DRIVE: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q >= SETTLE_TC) state_d = ST_SAMPLE;
                else                    cnt_d   = cnt_inc;
            end
            ST_SAMPLE: begin
                cnt_d = '0;
                if (rs != 4'hF && one_low(rs)) begin
                    row_idx_d = low_idx(rs);
                    state_d   = ST_DEBOUNCE;
                end else begin
                    // Idle column or ghosted multi-press: move on without latching.
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = ST_DRIVE;
                end
            end
            ST_DEBOUNCE: begin
                if (rs != row_pat) begin
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = ST_DRIVE;
                end else if (cnt_q >= DEB_TC) begin
                    key_code_d  = keymap(row_idx_q, col_idx_q);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = ST_HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (rs == 4'hF) begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rs != 4'hF) begin
                    state_d = ST_HELD;
                end else if (cnt_q >= DEB_TC) begin
                    key_held_d = 1'b0;
                    col_idx_d  = col_idx_q + 2'd1;
                    state_d    = ST_DRIVE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_DRIVE;
        endcase
    end

    assign kp.col       = ~(4'b0001 << col_idx_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: switch-matrix model, directed presses, scoreboard monitor on KEY_VALID.
module tb_keypad_scanner;
    localparam int SETTLE = 2;
    localparam int DEB    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kp();

    keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .kp     (kp)
    );

    // closed[r*4+c] = switch (r,c) made
    logic [15:0] closed = 16'h0;
    logic [3:0]  row_m;
    always_comb begin
        row_m = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (closed[r*4+c] && !kp.col[c]) row_m[r] = 1'b0;
    end
    assign kp.row = row_m;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic [7:0] exp_tab[16];
    logic [3:0] col_seq[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && kp.key_valid) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: key_valid=1 code=%0h, expected no pulse", kp.key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (kp.key_code !== mon_exp) begin
                    errors++;
                    $display("FAIL key_code: got %0h, expected %0h", kp.key_code, mon_exp);
                end
                checks++;
                if (kp.key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL held_with_valid: got %0b, expected 1", kp.key_held);
                end
            end
        end
    end

    task automatic wait_pulses(input string name, input int target, input int budget);
        for (int i = 0; i < budget && pulses < target; i++) @(negedge clk);
        @(negedge clk);
        check(name, pulses, target);
    endtask

    task automatic wait_held_low(input string name, input int budget);
        for (int i = 0; i < budget && kp.key_held !== 1'b0; i++) @(negedge clk);
        check(name, kp.key_held, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] val, input int budget);
        for (int i = 0; i < budget && kp.col !== val; i++) @(negedge clk);
        check("wait_col", kp.col, val);
    endtask

    task automatic set_key(input int idx, input logic v);
        @(posedge clk);
        #1 closed[idx] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    int base;
    initial begin
        exp_tab[0]  = 8'h01; exp_tab[1]  = 8'h02; exp_tab[2]  = 8'h03; exp_tab[3]  = 8'h0A;
        exp_tab[4]  = 8'h04; exp_tab[5]  = 8'h05; exp_tab[6]  = 8'h06; exp_tab[7]  = 8'h0B;
        exp_tab[8]  = 8'h07; exp_tab[9]  = 8'h08; exp_tab[10] = 8'h09; exp_tab[11] = 8'h0E;
        exp_tab[12] = 8'h0F; exp_tab[13] = 8'h00; exp_tab[14] = 8'h0C; exp_tab[15] = 8'h0D;
        col_seq[0] = 4'b1110; col_seq[1] = 4'b1101; col_seq[2] = 4'b1011; col_seq[3] = 4'b0111;

        repeat (3) @(negedge clk);
        check("rst_col", kp.col, 4'b1110);
        check("rst_code", kp.key_code, 8'h00);
        check("rst_valid", kp.key_valid, 0);
        check("rst_held", kp.key_held, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle rotation: each column occupies 4 cycles, revolution of 16.
        wait_col(4'b1101, 40);
        for (int k = 0; k <= 16; k++) begin
            check("idle_col", kp.col, col_seq[(1 + k / 4) % 4]);
            @(negedge clk);
        end

        // Key 6 held, then release timing.
        base = pulses;
        exp_q.push_back(8'h06);
        set_key(6, 1'b1);
        wait_pulses("press6_pulse", base + 1, 200);
        check("press6_held", kp.key_held, 1);
        repeat (40) @(negedge clk);
        check("press6_no_repeat", pulses, base + 1);
        set_key(6, 1'b0);
        repeat (10) @(posedge clk);
        #1 check("release6_before", kp.key_held, 1);
        @(posedge clk);
        #1 check("release6_after", kp.key_held, 0);
        check("release6_code_hold", kp.key_code, 8'h06);
        repeat (4) @(negedge clk);

        // Bouncing clear key.
        base = pulses;
        for (int b = 0; b < 4; b++) begin
            set_key(12, 1'b1);
            repeat (2) @(posedge clk);
            set_key(12, 1'b0);
            @(posedge clk);
        end
        check("bounce_no_pulse", pulses, base);
        exp_q.push_back(8'h0F);
        set_key(12, 1'b1);
        wait_pulses("bounce_pulse", base + 1, 200);
        set_key(12, 1'b0);
        wait_held_low("bounce_release", 100);

        // Ghost: two rows in column 1.
        base = pulses;
        set_key(1, 1'b1);
        set_key(9, 1'b1);
        repeat (60) @(negedge clk);
        check("ghost_no_pulse", pulses, base);
        exp_q.push_back(8'h02);
        set_key(9, 1'b0);
        wait_pulses("ghost_resolved", base + 1, 200);
        set_key(1, 1'b0);
        wait_held_low("ghost_release", 100);

        // Long hold of '-', a second key during hold is dropped.
        base = pulses;
        exp_q.push_back(8'h0D);
        set_key(15, 1'b1);
        wait_pulses("minus_pulse", base + 1, 200);
        repeat (20) @(negedge clk);
        set_key(0, 1'b1);
        repeat (180) @(negedge clk);
        check("minus_single", pulses, base + 1);
        check("minus_code", kp.key_code, 8'h0D);
        exp_q.push_back(8'h01);
        set_key(15, 1'b0);
        wait_pulses("rescan_1", base + 2, 200);
        set_key(0, 1'b0);
        wait_held_low("rescan_release", 100);

        // Reset while debouncing '/'.
        base = pulses;
        wait_col(4'b1110, 40);
        set_key(11, 1'b1);
        wait_col(4'b0111, 40);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_col", kp.col, 4'b1110);
        check("midrst_code", kp.key_code, 8'h00);
        check("midrst_valid", kp.key_valid, 0);
        check("midrst_held", kp.key_held, 0);
        check("midrst_no_pulse", pulses, base);
        repeat (2) @(posedge clk);
        exp_q.push_back(8'h0E);
        #1 rst_n = 1'b1;
        wait_pulses("postrst_pulse", base + 1, 200);
        set_key(11, 1'b0);
        wait_held_low("postrst_release", 100);

        // Walk every key in row-major order.
        for (int i = 0; i < 16; i++) begin
            base = pulses;
            exp_q.push_back(exp_tab[i]);
            set_key(i, 1'b1);
            wait_pulses("walk_pulse", base + 1, 200);
            set_key(i, 1'b0);
            wait_held_low("walk_release", 100);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, debounces presses and emits one 8-bit key code per press in the LCD character-code encoding. Sits directly upstream of the HD44780 LCD driver: KEY_CODE feeds its dataIn, and KEY_VALID marks each new press for any control logic.

## Interface
- SETTLE_CYCLES, default 16: cycles a newly driven column settles before rows are sampled (≥1).
- DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a press or a release (≥2).
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset; one clock; reset is asynchronous and active-low.
- ROW  input  4  keypad rows, active-low, externally pulled up, asynchronous to CLK.
- COL  output  4  column drive, one-cold (exactly one bit low at all times).
- KEY_CODE  output  8  code of the last accepted key; holds until the next press.
- KEY_VALID  output  1  one-cycle pulse when KEY_CODE updates.
- KEY_HELD  output  1  high from acceptance until debounced release.

## Operation
- ROW passes through a two-flop synchronizer. All decisions use the synchronized value rs.
- Key map (row r, col c): r0 = 1, 2, 3, (; r1 = 4, 5, 6, ); r2 = 7, 8, 9, /; r3 = clear, 0, =, -.
- Codes: digits 8'h00–8'h09; ( 8'h0A; ) 8'h0B; = 8'h0C; - 8'h0D; / 8'h0E; clear 8'h0F. No key produces other values.
- States: DRIVE, SETTLE, SAMPLE, DEBOUNCE, HELD, RELEASE.
- DRIVE: COL = ~(4'b1 << col_idx); clear the counter; go to SETTLE.
- SETTLE: count to SETTLE_CYCLES-1, then go to SAMPLE.
- SAMPLE, rs == 4'hF: col_idx advances (wraps 3→0); go to DRIVE.
- SAMPLE, exactly one rs bit low: latch that row pattern; go to DEBOUNCE.
- SAMPLE, two or more rs bits low: treat as ghost/multi-press; advance col_idx; go to DRIVE.
- DEBOUNCE: column stays driven.
  - rs equals the latched pattern for DEBOUNCE_CYCLES consecutive cycles: register KEY_CODE, pulse KEY_VALID, set KEY_HELD, go to HELD.
  - Any mismatch: advance col_idx; go to DRIVE. No code is emitted.
- HELD: column stays driven.
  - rs == 4'hF: clear the counter; go to RELEASE.
- RELEASE:
  - rs == 4'hF for DEBOUNCE_CYCLES consecutive cycles: clear KEY_HELD, advance col_idx, go to DRIVE.
  - Any low bit: return to HELD.
- No auto-repeat: a held key yields exactly one KEY_VALID.
- Presses on other columns while in HELD/RELEASE are invisible and are dropped.
- Counter width is $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES))+1. The counter saturates and never wraps.

## Timing
- Reset values:
  - COL = 4'b1110 (col_idx 0).
  - KEY_CODE = 8'h00, KEY_VALID = 0, KEY_HELD = 0.
  - State = DRIVE, counter = 0, synchronizer flops = 4'hF.
- Assertion of RST_N mid-operation forces reset values immediately, with no partial code emitted. Deassertion is synchronized internally (reset synchronizer) before the FSM leaves DRIVE.
- Scan period: 4 × (SETTLE_CYCLES + 2) cycles per full revolution with no key pressed.
- Accept latency, measured from the SAMPLE cycle that sees the press: DEBOUNCE_CYCLES + 1 cycles to KEY_VALID high.
- KEY_CODE and KEY_HELD change in the same cycle as the KEY_VALID pulse. KEY_VALID is high exactly one cycle.
- Release latency, measured from the first synchronized all-high cycle: DEBOUNCE_CYCLES + 1 cycles to KEY_HELD low.
- A rs change on the same cycle the counter reaches terminal count: the mismatch wins, and the press/release is not accepted.

## Structure
- keypad_pkg holds:
  - the state enum;
  - localparams for the 16 key codes (shared with the LCD driver's decode);
  - a function keymap(row_idx, col_idx) returning the code.
- One sub-module, sync2: a parameterized-width two-flop synchronizer with an asynchronous active-low reset value input, instantiated for ROW.

## Test plan
Bench parameters: SETTLE_CYCLES=2, DEBOUNCE_CYCLES=8. The keypad model pulls ROW[r] low while COL[c] is low and key (r,c) is closed.
- Press (1,2)=6 and hold 40 cycles → one KEY_VALID pulse, KEY_CODE=8'h06, KEY_HELD=1. Release → KEY_HELD=0 nine cycles after the synchronized release.
- Press (3,0)=clear, bouncing 3 cycles closed / 2 open for 20 cycles, then stable → exactly one KEY_VALID, KEY_CODE=8'h0F, no pulse during the bounce.
- Close (0,1) and (2,1) together → no KEY_VALID. Release (2,1) only → KEY_VALID with KEY_CODE=8'h02.
- Hold (3,3)=- for 200 cycles → exactly one pulse, KEY_CODE=8'h0D. Press (0,0) during the hold → ignored. After release and a rescan → 8'h01.
- Assert RST_N low during DEBOUNCE of (2,3) → COL=4'b1110, KEY_CODE=8'h00, KEY_VALID=0 at once. After deassert with the key still held → normal acceptance of 8'h0E.
- Walk all 16 keys in order → KEY_CODE sequence matches the key map. Idle COL rotates 1110→1101→1011→0111→1110 with a period of 16 cycles.
